// File: rtl/srv32_seq.sv
// srv32_seq: multi-cycle 32-bit logical/arithmetic right shifter, STEP bits per clock
module srv32_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        arith,
  output logic [31:0] res,
  output logic        busy,
  output logic        done
);
  if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8 && STEP != 16) begin : g_step_chk
    $error("srv32_seq: STEP must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [4:0] S = 5'(STEP);
  state_t state, state_n;
  logic [31:0] acc, acc_n;
  logic [4:0] rem, rem_n, n;
  logic fill, fill_n;
  always_comb begin
    state_n = state;
    acc_n = acc;
    rem_n = rem;
    fill_n = fill;
    n = rem < S ? rem : S;
    if (state == IDLE && start) begin
      acc_n = A;
      rem_n = B[4:0];
      fill_n = arith & A[31];
      state_n = B[4:0] == 5'd0 ? DONE : SHIFT;
    end else if (state == SHIFT) begin
      // the 33-bit signed shift drags fill into the vacated top bits
      acc_n = 32'($signed({fill, acc}) >>> n);
      rem_n = rem - n;
      state_n = rem_n == 5'd0 ? DONE : SHIFT;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      rem <= '0;
      fill <= 1'b0;
      res <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      rem <= rem_n;
      fill <= fill_n;
      res <= state_n == DONE ? acc_n : res;
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_srv32_seq.sv
// tb_srv32_seq: directed vector table plus handshake corner cases across STEP = 1,2,4,8,16
module tb_srv32_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] start = '0;
  logic [31:0] a = '0, b = '0;
  logic ar = 1'b0;
  logic [31:0] res_w [5];
  logic busy_w [5];
  logic done_w [5];
  int ncmp = 0, nbad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    srv32_seq #(.STEP(1 << g)) u (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .A(a), .B(b), .arith(ar),
      .res(res_w[g]), .busy(busy_w[g]), .done(done_w[g])
    );
  end
  typedef struct {
    int d;
    logic [31:0] a, b;
    logic ar;
    logic [31:0] er;
    int el;
  } vec_t;
  vec_t vecs [12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv, input logic arv,
                        input logic [31:0] er, input int el, input string nm);
    int lat, bc;
    @(negedge clk);
    a = av; b = bv; ar = arv; start[d] = 1'b1;
    lat = 0; bc = 0;
    do begin
      @(negedge clk);
      start[d] = 1'b0;
      a = ~av; b = ~bv; ar = ~arv;
      lat++;
      if (busy_w[d]) bc++;
    end while (!done_w[d] && lat < 64);
    chk({nm, " latency"}, 32'(lat), 32'(el));
    chk({nm, " res"}, res_w[d], er);
    chk({nm, " busy cycles"}, 32'(bc), 32'(el));
    @(negedge clk);
    chk({nm, " done pulse width"}, {31'd0, done_w[d]}, 32'd0);
    chk({nm, " busy after done"}, {31'd0, busy_w[d]}, 32'd0);
    chk({nm, " res hold"}, res_w[d], er);
  endtask
  initial begin
    int dc, dcyc;
    logic [31:0] av, bv, er;
    logic arv;
    vecs[0]  = '{0, 32'h80000000, 32'd31,       1'b1, 32'hFFFFFFFF, 32};
    vecs[1]  = '{2, 32'hF0001234, 32'h00000025, 1'b0, 32'h07800091, 3};
    vecs[2]  = '{2, 32'hF0001234, 32'h00000025, 1'b1, 32'hFF800091, 3};
    vecs[3]  = '{0, 32'hDEADBEEF, 32'h00000000, 1'b1, 32'hDEADBEEF, 1};
    vecs[4]  = '{0, 32'hDEADBEEF, 32'h00000020, 1'b1, 32'hDEADBEEF, 1};
    vecs[5]  = '{0, 32'hDEADBEEF, 32'hFFFFFFE1, 1'b0, 32'h6F56DF77, 2};
    vecs[6]  = '{4, 32'h80000000, 32'd31,       1'b1, 32'hFFFFFFFF, 3};
    vecs[7]  = '{3, 32'h12345678, 32'd12,       1'b1, 32'h00012345, 3};
    vecs[8]  = '{1, 32'h80000001, 32'd3,        1'b0, 32'h10000000, 3};
    vecs[9]  = '{4, 32'hFFFF0000, 32'd16,       1'b0, 32'h0000FFFF, 2};
    vecs[10] = '{3, 32'h87654321, 32'd7,        1'b1, 32'hFF0ECA86, 2};
    vecs[11] = '{1, 32'h80000000, 32'd1,        1'b1, 32'hC0000000, 2};
    #12;
    for (int i = 0; i < 5; i++) begin
      chk("reset res", res_w[i], 32'd0);
      chk("reset busy", {31'd0, busy_w[i]}, 32'd0);
      chk("reset done", {31'd0, done_w[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].ar, vecs[i].er, vecs[i].el, $sformatf("vec%0d", i));
    // second request lands in SHIFT and must be dropped
    @(negedge clk);
    a = 32'h100; b = 32'd8; ar = 1'b0; start[0] = 1'b1;
    dc = 0; dcyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start[0] = i == 2;
      if (i == 2) begin a = '1; b = 32'd1; end
      if (done_w[0]) begin dc++; dcyc = i; end
    end
    chk("busy-protect done count", 32'(dc), 32'd1);
    chk("busy-protect latency", 32'(dcyc), 32'd9);
    chk("busy-protect res", res_w[0], 32'h00000001);
    // asynchronous reset in the third SHIFT cycle
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'd20; ar = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midop reset res", res_w[0], 32'd0);
    chk("midop reset busy", {31'd0, busy_w[0]}, 32'd0);
    chk("midop reset done", {31'd0, done_w[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) dc++;
    end
    chk("midop reset no activity", 32'(dc), 32'd0);
    run_op(0, 32'h0000F000, 32'd4, 1'b0, 32'h00000F00, 5, "post-reset");
    for (int d = 0; d < 5; d++) begin
      for (int k = 0; k < 1000; k++) begin
        av = $urandom;
        bv = $urandom;
        arv = 1'($urandom_range(0, 1));
        er = arv ? 32'($signed(av) >>> bv[4:0]) : av >> bv[4:0];
        run_op(d, av, bv, arv, er, (int'(bv[4:0]) + (1 << d) - 1) / (1 << d) + 1,
               $sformatf("rand s%0d a=%h b=%h ar=%0d", 1 << d, av, bv, arv));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
